mask_decompose: RTL

MASK_DECOMPOSE -- requirements
Module: mask_decompose

---
 rtl/mask_decompose.sv | 98 +++++++++
 1 files changed

// File: rtl/mask_decompose.sv
// Splits a 32-bit mask word into its one-hot components, lowest bit first,
// one beat per output handshake; an all-zero word yields a single "zero" beat.
//
// state | meaning
// IDLE  | waiting for a word; in_ready high
// EMIT  | streaming components of the latched word; out_valid high
module mask_decompose (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_onehot,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        out_zero,
  output logic [5:0]  beat_count
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] residual, residual_next;
  logic [5:0]  count, count_next;
  logic [31:0] low_bit;
  logic [31:0] rest;
  logic [4:0]  low_idx;
  logic        is_last;
  logic        emit;

  assign low_bit = residual & (~residual + 32'd1);
  assign rest    = residual & (residual - 32'd1);
  assign is_last = (rest == 32'd0);
  assign emit    = (state == EMIT);

  // low_bit is one-hot (or zero), so OR-ing set positions gives its index
  always_comb begin
    low_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (low_bit[i]) low_idx = low_idx | 5'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      residual <= 32'd0;
      count    <= 6'd0;
    end else begin
      state    <= state_next;
      residual <= residual_next;
      count    <= count_next;
    end
  end

  always_comb begin
    state_next    = state;
    residual_next = residual;
    count_next    = count;
    case (state)
      IDLE: begin
        if (in_valid) begin
          residual_next = data_operand;
          count_next    = 6'd0;
          state_next    = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (is_last) begin
            residual_next = 32'd0;
            count_next    = 6'd0;
            state_next    = IDLE;
          end else begin
            residual_next = rest;
            count_next    = count + 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // residual only reaches zero inside EMIT when the accepted word was zero
  assign in_ready   = (state == IDLE);
  assign out_valid  = emit;
  assign out_onehot = emit ? low_bit : 32'd0;
  assign out_index  = emit ? low_idx : 5'd0;
  assign out_last   = emit & is_last;
  assign out_zero   = emit & (residual == 32'd0);
  assign beat_count = emit ? count : 6'd0;

endmodule
